// File: rtl/alu_seq_param.sv
// Registered, parametrised adder/subtractor ALU with accumulator, modulo step ops,
// status flags and a one-cycle out_valid pulse per accepted request.
module alu_seq_param #(
    parameter int WIDTH = 8,
    parameter int MOD   = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf,
    output logic             wrap,
    output logic             out_valid,
    output logic [WIDTH-1:0] acc,
    output logic             ovf_sticky
);

    typedef enum logic [2:0] {
        OP_PASS   = 3'b000,
        OP_ADD    = 3'b001,
        OP_SUB    = 3'b010,
        OP_INC    = 3'b011,
        OP_ACC    = 3'b100,
        OP_CLRACC = 3'b101,
        OP_MODINC = 3'b110,
        OP_MODDEC = 3'b111
    } op_e;

    localparam logic [WIDTH:0] MOD_X    = (WIDTH+1)'(MOD);
    localparam logic [WIDTH:0] MOD_M1_X = MOD_X - {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] ONE_X    = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             wrap_q, wrap_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_sticky_q, ovf_sticky_d;

    logic [WIDTH:0]   a_x, b_x, acc_x, sum_x;
    logic [WIDTH-1:0] op_res;
    logic             op_cout, op_ovf, op_wrap;
    op_e              op_sel;

    assign a_x    = {1'b0, a};
    assign b_x    = {1'b0, b};
    assign acc_x  = {1'b0, acc_q};
    assign op_sel = op_e'(op);

    // Every op is evaluated one bit wider than the operands so the top bit is the carry.
    always_comb begin
        sum_x   = '0;
        op_res  = '0;
        op_cout = 1'b0;
        op_ovf  = 1'b0;
        op_wrap = 1'b0;
        case (op_sel)
            OP_PASS: begin
                op_res = a;
            end
            OP_ADD: begin
                sum_x   = a_x + b_x + {{WIDTH{1'b0}}, cin};
                op_res  = sum_x[WIDTH-1:0];
                op_cout = sum_x[WIDTH];
                op_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_x[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum_x   = a_x + {1'b0, ~b} + ONE_X;
                op_res  = sum_x[WIDTH-1:0];
                op_cout = sum_x[WIDTH];
                op_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sum_x[WIDTH-1] != a[WIDTH-1]);
            end
            OP_INC: begin
                sum_x   = a_x + ONE_X;
                op_res  = sum_x[WIDTH-1:0];
                op_cout = sum_x[WIDTH];
            end
            OP_ACC: begin
                sum_x   = acc_x + b_x;
                op_res  = sum_x[WIDTH-1:0];
                op_cout = sum_x[WIDTH];
                op_ovf  = (acc_q[WIDTH-1] == b[WIDTH-1]) && (sum_x[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_CLRACC: begin
                op_res = '0;
            end
            OP_MODINC: begin
                // Out-of-range digits roll to zero just like the top valid digit.
                if (a_x >= MOD_M1_X) begin
                    op_res  = '0;
                    op_wrap = 1'b1;
                end else begin
                    sum_x  = a_x + ONE_X;
                    op_res = sum_x[WIDTH-1:0];
                end
            end
            OP_MODDEC: begin
                if ((a == '0) || (a_x >= MOD_X)) begin
                    op_res  = MOD_M1_X[WIDTH-1:0];
                    op_wrap = 1'b1;
                end else begin
                    op_res = a - {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                op_res = '0;
            end
        endcase
    end

    always_comb begin
        result_d     = result_q;
        cout_d       = cout_q;
        zero_d       = zero_q;
        ovf_d        = ovf_q;
        wrap_d       = wrap_q;
        acc_d        = acc_q;
        out_valid_d  = in_valid;
        ovf_sticky_d = ovf_sticky_q;

        if (in_valid) begin
            result_d = op_res;
            cout_d   = op_cout;
            zero_d   = (op_res == '0);
            ovf_d    = op_ovf;
            wrap_d   = op_wrap;
            if (op_sel == OP_ACC) begin
                acc_d = op_res;
            end else if (op_sel == OP_CLRACC) begin
                acc_d = '0;
            end
        end

        // A fresh overflow beats a same-cycle clear.
        if (in_valid && op_ovf) begin
            ovf_sticky_d = 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q     <= '0;
            cout_q       <= 1'b0;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
            wrap_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            acc_q        <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            result_q     <= result_d;
            cout_q       <= cout_d;
            zero_q       <= zero_d;
            ovf_q        <= ovf_d;
            wrap_q       <= wrap_d;
            out_valid_q  <= out_valid_d;
            acc_q        <= acc_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign result     = result_q;
    assign cout       = cout_q;
    assign zero       = zero_q;
    assign ovf        = ovf_q;
    assign wrap       = wrap_q;
    assign out_valid  = out_valid_q;
    assign acc        = acc_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed-vector bench for alu_seq_param at WIDTH=8, MOD=60: a vector table
// plus hand sequences for hold, sticky overflow and mid-request reset.
module tb_alu_seq_param;

    localparam int WIDTH = 8;
    localparam int MOD   = 60;

    localparam logic [2:0] PASS   = 3'b000;
    localparam logic [2:0] ADD    = 3'b001;
    localparam logic [2:0] SUB    = 3'b010;
    localparam logic [2:0] INC    = 3'b011;
    localparam logic [2:0] ACC    = 3'b100;
    localparam logic [2:0] CLRACC = 3'b101;
    localparam logic [2:0] MODINC = 3'b110;
    localparam logic [2:0] MODDEC = 3'b111;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             clr_sticky;
    logic [WIDTH-1:0] result;
    logic             cout, zero, ovf, wrap, out_valid;
    logic [WIDTH-1:0] acc;
    logic             ovf_sticky;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] res;
        logic       cout;
        logic       zero;
        logic       ovf;
        logic       wrap;
        logic [7:0] acc;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    alu_seq_param #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .op         (op),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .clr_sticky (clr_sticky),
        .result     (result),
        .cout       (cout),
        .zero       (zero),
        .ovf        (ovf),
        .wrap       (wrap),
        .out_valid  (out_valid),
        .acc        (acc),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    // Drives one cycle's inputs on the falling edge, then waits until just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [7:0] av,
                                 input logic [7:0] bv, input logic c, input logic clr);
        @(negedge clk);
        in_valid   = v;
        op         = o;
        a          = av;
        b          = bv;
        cin        = c;
        clr_sticky = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        // op, a, b, cin, result, cout, zero, ovf, wrap, acc
        vecs[0]  = '{CLRACC, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{ADD,    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{ADD,    8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[3]  = '{ADD,    8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{SUB,    8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{SUB,    8'h05, 8'h03, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{SUB,    8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[7]  = '{PASS,   8'hA5, 8'hFF, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{INC,    8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{INC,    8'h41, 8'h00, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{MODINC, 8'd58,  8'h00, 1'b0, 8'd59, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{MODINC, 8'd59,  8'h00, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[12] = '{MODINC, 8'd200, 8'h00, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
        vecs[13] = '{MODDEC, 8'd0,   8'h00, 1'b0, 8'd59, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[14] = '{MODDEC, 8'd30,  8'h00, 1'b0, 8'd29, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[15] = '{MODDEC, 8'd60,  8'h00, 1'b0, 8'd59, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[16] = '{CLRACC, 8'h55, 8'h66, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[17] = '{ACC,    8'h00, 8'd10, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10};
        vecs[18] = '{ACC,    8'h00, 8'd10, 1'b0, 8'd20, 1'b0, 1'b0, 1'b0, 1'b0, 8'd20};
        vecs[19] = '{ACC,    8'h00, 8'd10, 1'b0, 8'd30, 1'b0, 1'b0, 1'b0, 1'b0, 8'd30};
        vecs[20] = '{ACC,    8'h00, 8'h60, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7E};
        vecs[21] = '{ACC,    8'h00, 8'h10, 1'b0, 8'h8E, 1'b0, 1'b0, 1'b1, 1'b0, 8'h8E};
        vecs[22] = '{ACC,    8'h00, 8'h80, 1'b0, 8'h0E, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0E};
        vecs[23] = '{PASS,   8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0E};

        reset      = 1'b1;
        in_valid   = 1'b0;
        op         = PASS;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        clr_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset result", 32'(result), 32'h0);
        checkOutput("reset cout", 32'(cout), 32'h0);
        checkOutput("reset zero", 32'(zero), 32'h0);
        checkOutput("reset ovf", 32'(ovf), 32'h0);
        checkOutput("reset wrap", 32'(wrap), 32'h0);
        checkOutput("reset out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset acc", 32'(acc), 32'h0);
        checkOutput("reset ovf_sticky", 32'(ovf_sticky), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Vectors go in on consecutive edges, so every row also checks a back-to-back out_valid pulse.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
            checkOutput($sformatf("v%0d result", i), 32'(result), 32'(vecs[i].res));
            checkOutput($sformatf("v%0d cout", i), 32'(cout), 32'(vecs[i].cout));
            checkOutput($sformatf("v%0d zero", i), 32'(zero), 32'(vecs[i].zero));
            checkOutput($sformatf("v%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
            checkOutput($sformatf("v%0d wrap", i), 32'(wrap), 32'(vecs[i].wrap));
            checkOutput($sformatf("v%0d out_valid", i), 32'(out_valid), 32'h1);
            checkOutput($sformatf("v%0d acc", i), 32'(acc), 32'(vecs[i].acc));
        end

        // Idle cycle: outputs hold, out_valid drops.
        applyStimulus(1'b1, PASS, 8'h3C, 8'h00, 1'b0, 1'b0);
        checkOutput("pass 3C result", 32'(result), 32'h3C);
        applyStimulus(1'b0, ACC, 8'h99, 8'h01, 1'b0, 1'b0);
        checkOutput("idle out_valid", 32'(out_valid), 32'h0);
        checkOutput("idle result hold", 32'(result), 32'h3C);
        checkOutput("idle acc hold", 32'(acc), 32'h0E);

        // Sticky overflow: set by the table, cleared without a request, then set-wins-over-clear.
        checkOutput("sticky after table", 32'(ovf_sticky), 32'h1);
        applyStimulus(1'b0, PASS, 8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("sticky cleared idle", 32'(ovf_sticky), 32'h0);
        applyStimulus(1'b1, ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
        checkOutput("sticky set ovf", 32'(ovf), 32'h1);
        checkOutput("sticky set", 32'(ovf_sticky), 32'h1);
        applyStimulus(1'b1, ADD, 8'h7F, 8'h01, 1'b0, 1'b1);
        checkOutput("sticky set wins", 32'(ovf_sticky), 32'h1);
        applyStimulus(1'b1, ADD, 8'h01, 8'h01, 1'b0, 1'b1);
        checkOutput("sticky clr with add result", 32'(result), 32'h02);
        checkOutput("sticky clr with add", 32'(ovf_sticky), 32'h0);

        // Build up state, then reset in the middle of a pending ADD request.
        applyStimulus(1'b1, ACC, 8'h00, 8'h33, 1'b0, 1'b0);
        checkOutput("pre-reset acc", 32'(acc), 32'h41);
        applyStimulus(1'b1, ADD, 8'h7F, 8'h7F, 1'b0, 1'b0);
        checkOutput("pre-reset sticky", 32'(ovf_sticky), 32'h1);
        @(negedge clk);
        in_valid = 1'b1;
        op       = ADD;
        a        = 8'd5;
        b        = 8'd3;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset result", 32'(result), 32'h0);
        checkOutput("midreset cout", 32'(cout), 32'h0);
        checkOutput("midreset ovf", 32'(ovf), 32'h0);
        checkOutput("midreset out_valid", 32'(out_valid), 32'h0);
        checkOutput("midreset acc", 32'(acc), 32'h0);
        checkOutput("midreset ovf_sticky", 32'(ovf_sticky), 32'h0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post-reset out_valid", 32'(out_valid), 32'h0);
        checkOutput("post-reset result", 32'(result), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("post-reset out_valid 2", 32'(out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
